// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for MIPS DIV/DIVU.
// Retires one quotient bit per clock. The result is {remainder, quotient}.
//
// Ports:
//   clk           clock; all state changes on the rising edge
//   rst           synchronous, active-high reset
//   signed_div_i  1 = signed divide (DIV), 0 = unsigned divide (DIVU)
//   opdata1_i     dividend, latched when a request is accepted
//   opdata2_i     divisor, latched when a request is accepted
//   start_i       request; EX holds it high until it has consumed the result
//   annul_i       cancels the in-flight division (exception or branch flush)
//   result_o      {HI = remainder, LO = quotient}, registered
//   ready_o       result valid, registered
module div_unit #(
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                start_i,
    input  logic                annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o
);

    localparam int unsigned      CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DATA_W);

    typedef enum logic [1:0] {
        FREE,
        BYZERO,
        ON,
        END
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] rem;      // partial remainder
    logic [DATA_W-1:0] dvd;      // dividend bits still to consume, quotient bits shifted in
    logic [DATA_W-1:0] dvs;      // divisor magnitude
    logic              neg_quo;
    logic              neg_rem;

    logic [DATA_W:0]   shifted;
    logic [DATA_W:0]   diff;
    logic [DATA_W-1:0] quo_fix;
    logic [DATA_W-1:0] rem_fix;
    logic [DATA_W-1:0] mag1;
    logic [DATA_W-1:0] mag2;

    // The partial remainder stays below the divisor, so DATA_W bits hold it
    // between steps; the shifted trial value needs one extra bit, and the top
    // bit of the trial difference is the borrow (negative result).
    always_comb begin
        shifted = {rem, dvd[DATA_W-1]};
        diff    = shifted - {1'b0, dvs};
        quo_fix = neg_quo ? -dvd : dvd;
        rem_fix = neg_rem ? -rem : rem;
        mag1    = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
        mag2    = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FREE;
            cnt      <= '0;
            ready_o  <= 1'b0;
            result_o <= '0;
            rem      <= '0;
            dvd      <= '0;
            dvs      <= '0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
        end else begin
            case (state)
                FREE: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                    if (start_i && !annul_i) begin
                        if (opdata2_i == '0) begin
                            state <= BYZERO;
                        end else begin
                            state   <= ON;
                            cnt     <= '0;
                            rem     <= '0;
                            dvd     <= mag1;
                            dvs     <= mag2;
                            neg_quo <= signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                            neg_rem <= signed_div_i & opdata1_i[DATA_W-1];
                        end
                    end
                end

                BYZERO: begin
                    result_o <= '0;
                    if (annul_i) begin
                        state   <= FREE;
                        ready_o <= 1'b0;
                    end else begin
                        state   <= END;
                        ready_o <= 1'b1;
                    end
                end

                ON: begin
                    // A flush wins over completion on the same edge.
                    if (annul_i) begin
                        state    <= FREE;
                        ready_o  <= 1'b0;
                        result_o <= '0;
                    end else if (cnt == CNT_DONE) begin
                        state    <= END;
                        ready_o  <= 1'b1;
                        result_o <= {rem_fix, quo_fix};
                    end else begin
                        rem <= diff[DATA_W] ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
                        dvd <= {dvd[DATA_W-2:0], ~diff[DATA_W]};
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                END: begin
                    if (!start_i || annul_i) begin
                        state    <= FREE;
                        ready_o  <= 1'b0;
                        result_o <= '0;
                    end
                end

                default: begin
                    state    <= FREE;
                    ready_o  <= 1'b0;
                    result_o <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: self-checking bench for div_unit (DATA_W = 32).
// Requests are driven by the main process, which queues the expected result
// and the cycle at which ready_o must rise; a negedge monitor pops and checks
// on every rising ready_o.
module tb_div_unit;

    localparam int unsigned W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           signed_div_i;
    logic [W-1:0]   op1;
    logic [W-1:0]   op2;
    logic           start_i;
    logic           annul_i;
    logic [2*W-1:0] result_o;
    logic           ready_o;

    typedef struct {
        logic [2*W-1:0] result;
        int unsigned    cycle;
        string          name;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int unsigned cyc   = 0;
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic        prev_ready = 1'b0;

    div_unit #(.DATA_W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Monitor: every rising ready_o must match the oldest queued expectation.
    always @(negedge clk) begin
        if (ready_o === 1'b1 && prev_ready !== 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_ready: ready_o=1 at cycle %0d, required no pending request", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check({mon_e.name, "_result"}, result_o, mon_e.result);
                check({mon_e.name, "_latency"}, 64'(cyc), 64'(mon_e.cycle));
            end
        end
        prev_ready = ready_o;
    end

    // Called just after a rising edge with the unit in FREE. Drives the request,
    // queues the expectation, then scrambles the inputs after acceptance.
    task automatic issue(input string name, input logic sgn, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] q, input logic [W-1:0] r);
        exp_t e;
        signed_div_i = sgn;
        op1          = a;
        op2          = b;
        annul_i      = 1'b0;
        start_i      = 1'b1;
        e.result     = {r, q};
        e.cycle      = cyc + ((b == '0) ? 2 : 34);
        e.name       = name;
        exp_q.push_back(e);
        @(posedge clk); #1;
        op1          = ~a;
        op2          = b ^ 32'h5A5A_0003;
        signed_div_i = ~sgn;
    endtask

    // Waits (bounded) for ready_o, checks the result is held, then drops start_i.
    task automatic complete(input string name, input logic [W-1:0] q, input logic [W-1:0] r);
        bit seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            if (ready_o === 1'b1) seen = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        if (!seen) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: ready_o=0, required 1 within 80 cycles", name);
        end else begin
            repeat (3) begin
                @(posedge clk); #1;
            end
            check({name, "_hold_ready"}, 64'(ready_o), 64'd1);
            check({name, "_hold_result"}, result_o, {r, q});
        end
        start_i = 1'b0;
        @(posedge clk); #1;
        check({name, "_drop_ready"}, 64'(ready_o), 64'd0);
        check({name, "_drop_result"}, result_o, 64'd0);
    endtask

    task automatic run(input string name, input logic sgn, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] q, input logic [W-1:0] r);
        issue(name, sgn, a, b, q, r);
        complete(name, q, r);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        signed_div_i = 1'b0;
        op1          = '0;
        op2          = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", 64'(ready_o), 64'd0);
        check("reset_result", result_o, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run("u_100_7",    1'b0, 32'd100,        32'd7,          32'd14,         32'd2);
        run("s_m7_2",     1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF);
        run("s_7_m2",     1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1);
        run("u_fff9_2",   1'b0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1);
        run("s_min_m1",   1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0);
        run("u_max_1",    1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0);
        run("u_5_9",      1'b0, 32'd5,          32'd9,          32'd0,          32'd5);
        run("div_zero",   1'b0, 32'd1234,       32'd0,          32'd0,          32'd0);

        // Annul on the 10th iteration edge; the request must never complete.
        signed_div_i = 1'b0;
        op1          = 32'd1000;
        op2          = 32'd3;
        start_i      = 1'b1;
        @(posedge clk); #1;                 // acceptance edge
        repeat (9) begin
            @(posedge clk); #1;
        end
        annul_i = 1'b1;
        op1     = 32'd77;
        @(posedge clk); #1;                 // 10th iteration edge
        check("annul_ready", 64'(ready_o), 64'd0);
        check("annul_result", result_o, 64'd0);
        run("after_annul", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);

        // Synchronous reset at the 20th iteration edge.
        signed_div_i = 1'b0;
        op1          = 32'd5000;
        op2          = 32'd7;
        start_i      = 1'b1;
        @(posedge clk); #1;                 // acceptance edge
        repeat (19) begin
            @(posedge clk); #1;
        end
        rst     = 1'b1;
        start_i = 1'b0;
        @(posedge clk); #1;                 // 20th iteration edge
        check("rst_mid_ready", 64'(ready_o), 64'd0);
        check("rst_mid_result", result_o, 64'd0);
        rst = 1'b0;
        run("after_reset", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);

        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
